// File: rtl/hist_pkg.sv
// Shared constants, state encoding and bin helpers for the histogram readout slice.
package hist_pkg;

  localparam int unsigned NUM_BINS  = 11;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned FIRST_VAL = 17;
  localparam int unsigned BIN_SPAN  = 2;
  localparam int unsigned TOT_W     = CNT_W + IDX_W;
  localparam int unsigned LO_W      = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StFin  = 2'd2
  } hist_state_e;

  // Lowest sample value that falls into bin idx.
  function automatic logic [LO_W-1:0] bin_lo(input logic [IDX_W-1:0] idx);
    logic [LO_W-1:0] lo;
    lo = LO_W'(FIRST_VAL) + LO_W'(BIN_SPAN) * LO_W'(idx);
    return lo;
  endfunction

endpackage

// File: rtl/histogram_readout_if.sv
// Valid/ready beat stream carrying one histogram bin per transfer.
interface histogram_readout_if;
  import hist_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [LO_W-1:0]  out_lo;
  logic [CNT_W-1:0] out_count;
  logic             out_last;

  modport master (
    output out_valid,
    output out_idx,
    output out_lo,
    output out_count,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_lo,
    input  out_count,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/hist_stats_acc.sv
// Running total and mode (first largest count) over a stream of accepted bins.
module hist_stats_acc
  import hist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             accept,
  input  logic [IDX_W-1:0] idx,
  input  logic [CNT_W-1:0] count,
  output logic [TOT_W-1:0] total,
  output logic [IDX_W-1:0] mode_idx,
  output logic [CNT_W-1:0] mode_count
);

  logic [TOT_W-1:0] total_q;
  logic [IDX_W-1:0] mode_idx_q;
  logic [CNT_W-1:0] mode_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q      <= '0;
      mode_idx_q   <= '0;
      mode_count_q <= '0;
    end else if (clear) begin
      total_q      <= '0;
      mode_idx_q   <= '0;
      mode_count_q <= '0;
    end else if (accept) begin
      total_q <= total_q + TOT_W'(count);
      // Strict compare so ties keep the earlier (lower) index.
      if (count > mode_count_q) begin
        mode_idx_q   <= idx;
        mode_count_q <= count;
      end
    end
  end

  assign total      = total_q;
  assign mode_idx   = mode_idx_q;
  assign mode_count = mode_count_q;

endmodule

// File: rtl/histogram_readout.sv
// Snapshots the accumulator bins on start, requests a clear, then streams the bins out.
module histogram_readout
  import hist_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_BINS*CNT_W-1:0] bins_flat,
  output logic                      clear_req,
  output logic                      busy,
  output logic                      done,
  output logic [TOT_W-1:0]          total,
  output logic [IDX_W-1:0]          mode_idx,
  output logic [CNT_W-1:0]          mode_count,
  histogram_readout_if.master       stream
);

  hist_state_e               state_q;
  logic [NUM_BINS*CNT_W-1:0] snap_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      clear_q;
  logic                      busy_q;
  logic                      valid_q;
  logic                      done_q;

  logic                      accept;
  logic                      last;
  logic                      start_ok;
  logic [CNT_W-1:0]          cur_count;

  assign accept   = valid_q & stream.out_ready;
  assign last     = (idx_q == IDX_W'(NUM_BINS - 1));
  assign start_ok = (state_q == StIdle) & start;

  always_comb begin
    cur_count = '0;
    for (int i = 0; i < int'(NUM_BINS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_count = snap_q[i*CNT_W +: CNT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      snap_q  <= '0;
      idx_q   <= '0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            snap_q  <= bins_flat;
            idx_q   <= '0;
            clear_q <= 1'b1;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (accept) begin
            if (last) begin
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  hist_stats_acc u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .accept     (accept),
    .idx        (idx_q),
    .count      (cur_count),
    .total      (total),
    .mode_idx   (mode_idx),
    .mode_count (mode_count)
  );

  // Beat fields read as zero whenever no beat is offered.
  assign stream.out_valid = valid_q;
  assign stream.out_idx   = valid_q ? idx_q : '0;
  assign stream.out_lo    = valid_q ? bin_lo(idx_q) : '0;
  assign stream.out_count = valid_q ? cur_count : '0;
  assign stream.out_last  = valid_q & last;

  assign clear_req = clear_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_histogram_readout.sv
// Randomized self-checking bench for histogram_readout against an array-level reference model.
module tb_histogram_readout;
  import hist_pkg::*;

  localparam int NB = int'(NUM_BINS);

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic [NUM_BINS*CNT_W-1:0] bins_flat = '0;
  logic                      clear_req;
  logic                      busy;
  logic                      done;
  logic [TOT_W-1:0]          total;
  logic [IDX_W-1:0]          mode_idx;
  logic [CNT_W-1:0]          mode_count;

  histogram_readout_if stream_if ();

  histogram_readout dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bins_flat  (bins_flat),
    .clear_req  (clear_req),
    .busy       (busy),
    .done       (done),
    .total      (total),
    .mode_idx   (mode_idx),
    .mode_count (mode_count),
    .stream     (stream_if)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_bad = 0;
  string cur_case = "reset";

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d, expected %0d", cur_case, tag, got, exp);
    end
  endtask

  function automatic logic [NUM_BINS*CNT_W-1:0] pack_bins(input int b[NB]);
    logic [NUM_BINS*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[i*CNT_W +: CNT_W] = CNT_W'(b[i]);
    return v;
  endfunction

  task automatic check_idle_zero();
    check_eq("valid", int'(stream_if.out_valid), 0);
    check_eq("busy", int'(busy), 0);
    check_eq("done", int'(done), 0);
    check_eq("clear_req", int'(clear_req), 0);
    check_eq("total", int'(total), 0);
    check_eq("mode_idx", int'(mode_idx), 0);
    check_eq("mode_count", int'(mode_count), 0);
    check_eq("out_lo", int'(stream_if.out_lo), 0);
    check_eq("out_count", int'(stream_if.out_count), 0);
  endtask

  // One start/stream/done transaction; restart_beat/abort_beat < 0 disables those events.
  task automatic run_case(input string name, input int b[NB], input bit stall, input bit scramble,
                          input int restart_beat, input int abort_beat);
    int beat, cycles, clears, dones, exp_tot, exp_max, exp_mi;
    bit rdy, restarted;
    cur_case = name;
    exp_tot  = 0;
    exp_max  = 0;
    for (int i = 0; i < NB; i++) begin
      exp_tot += b[i];
      if (b[i] > exp_max) exp_max = b[i];
    end
    exp_mi = 0;
    for (int i = NB - 1; i >= 0; i--) if (b[i] == exp_max) exp_mi = i;

    @(negedge clk);
    bins_flat = pack_bins(b);
    start     = 1'b1;
    stream_if.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_first", int'(busy), 1);
    if (scramble) begin
      for (int i = 0; i < NB; i++) bins_flat[i*CNT_W +: CNT_W] = CNT_W'($urandom);
    end

    beat      = 0;
    cycles    = 0;
    clears    = 0;
    dones     = 0;
    restarted = 1'b0;
    while (beat < NB && cycles < 400) begin
      check_eq("valid", int'(stream_if.out_valid), 1);
      check_eq("idx", int'(stream_if.out_idx), beat);
      check_eq("lo", int'(stream_if.out_lo), 17 + 2 * beat);
      check_eq("count", int'(stream_if.out_count), b[beat]);
      check_eq("last", int'(stream_if.out_last), (beat == NB - 1) ? 1 : 0);
      clears += int'(clear_req);
      dones  += int'(done);
      if (beat == abort_beat) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_idle_zero();
        @(negedge clk);
        rst_n  = 1'b1;
        clears = 0;
        repeat (3) begin
          @(negedge clk);
          clears += int'(clear_req);
          dones  += int'(done);
        end
        check_eq("abort_clears", clears, 0);
        check_eq("abort_dones", dones, 0);
        check_eq("abort_busy", int'(busy), 0);
        return;
      end
      start = (beat == restart_beat) && !restarted;
      if (start) restarted = 1'b1;
      rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      stream_if.out_ready = rdy;
      @(negedge clk);
      cycles++;
      if (rdy) beat++;
    end
    start = 1'b0;

    check_eq("beats", beat, NB);
    if (!stall) check_eq("latency", cycles, NB);
    check_eq("clear_pulses", clears, 1);
    check_eq("early_done", dones, 0);
    check_eq("done", int'(done), 1);
    check_eq("busy_fin", int'(busy), 0);
    check_eq("valid_fin", int'(stream_if.out_valid), 0);
    check_eq("total", int'(total), exp_tot);
    check_eq("mode_idx", int'(mode_idx), exp_mi);
    check_eq("mode_count", int'(mode_count), exp_max);
    stream_if.out_ready = 1'b1;
    @(negedge clk);
    check_eq("done_single", int'(done), 0);
    check_eq("busy_idle", int'(busy), 0);
    check_eq("clear_idle", int'(clear_req), 0);
    check_eq("total_hold", int'(total), exp_tot);
    check_eq("mode_hold", int'(mode_count), exp_max);
  endtask

  initial begin
    int b[NB];
    stream_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero();
    check_eq("out_idx", int'(stream_if.out_idx), 0);
    rst_n = 1'b1;

    for (int i = 0; i < NB; i++) b[i] = 0;
    run_case("zeros", b, 1'b0, 1'b0, -1, -1);

    for (int i = 0; i < NB; i++) b[i] = i + 1;
    run_case("ramp", b, 1'b0, 1'b0, -1, -1);

    for (int i = 0; i < NB; i++) b[i] = 5;
    b[3] = 31;
    b[7] = 31;
    run_case("tie", b, 1'b0, 1'b0, -1, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NB; i++) b[i] = int'($urandom_range(0, 31));
      run_case("stall_rand", b, 1'b1, 1'b1, -1, -1);
    end

    for (int i = 0; i < NB; i++) b[i] = int'($urandom_range(0, 31));
    run_case("restart", b, 1'b0, 1'b0, 3, -1);

    for (int i = 0; i < NB; i++) b[i] = int'($urandom_range(1, 31));
    run_case("abort", b, 1'b0, 1'b0, -1, 5);

    for (int i = 0; i < NB; i++) b[i] = 2;
    run_case("after_abort", b, 1'b0, 1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/histogram_readout.md
Name: histogram_readout

Overview:
- Reader side of the team's binned-sample histogram accumulator. That accumulator produces 11 bins of 5-bit counts covering sample values 17..38, two values per bin.
- On `start`, this block snapshots all bin counts and requests a clear of the accumulator.
- It then streams the bins one at a time over a valid/ready interface, while computing the total sample count and the mode bin.
- It sits between the histogram accumulator and a downstream reporter (UART formatter or display driver).

Parameters:
- NUM_BINS, 11, number of bins in the snapshot.
- CNT_W, 5, width of each bin count.
- IDX_W, 4, width of the bin index; must satisfy 2^IDX_W >= NUM_BINS.
- FIRST_VAL, 17, lowest sample value covered by bin 0.
- BIN_SPAN, 2, number of sample values per bin.
- TOT_W (localparam), CNT_W+IDX_W = 9, width of the running total. It cannot overflow: 11*31 = 341 < 512.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to snapshot and stream; ignored while busy.
- bins_flat, input, NUM_BINS*CNT_W, bin counts; bin i occupies bits [i*CNT_W +: CNT_W], bin 0 at the LSBs.
- clear_req, output, 1, one-cycle pulse telling the accumulator to zero its bins.
- busy, output, 1, high from the cycle after start is accepted until done is high.
- out_valid, output, 1, the current beat is valid.
- out_ready, input, 1, downstream accepts the beat.
- out_idx, output, IDX_W, bin index of the current beat.
- out_lo, output, 6, lowest sample value of the current bin.
- out_count, output, CNT_W, snapshot count of the current bin.
- out_last, output, 1, the current beat is bin NUM_BINS-1.
- done, output, 1, one-cycle pulse after the final beat is accepted.
- total, output, TOT_W, sum of all streamed counts.
- mode_idx, output, IDX_W, index of the largest count.
- mode_count, output, CNT_W, value of the largest count.

Behaviour:
- Reset (async assert, clocked release):
  - State goes to IDLE.
  - All outputs are 0, including total, mode_idx and mode_count.
  - The snapshot register is cleared to 0.
- FSM has three states: IDLE, SEND, FIN.
- IDLE:
  - At a rising edge where start=1, the block registers bins_flat into the snapshot, zeroes idx/total/mode_idx/mode_count, and moves to SEND.
  - clear_req is high for exactly the next cycle, the first SEND cycle.
- SEND:
  - out_valid=1 and busy=1.
  - out_idx=idx, out_count=snapshot[idx], out_lo=FIRST_VAL+idx*BIN_SPAN, out_last=(idx==NUM_BINS-1).
  - All out_* signals are held stable until the handshake.
- Handshake (out_valid && out_ready at a rising edge):
  - total <= total + out_count.
  - If out_count > mode_count (strictly greater), mode_idx <= idx and mode_count <= out_count. Ties keep the lower index; an all-zero histogram gives mode_idx=0.
  - If out_last, move to FIN; otherwise idx <= idx+1.
- FIN:
  - out_valid=0, done=1 for one cycle, then return to IDLE.
  - busy is low in FIN.
- After FIN, total and mode_* hold their values until the next accepted start.
- Latency with out_ready held at 1:
  - start sampled at edge N.
  - Beats are accepted at edges N+1 through N+11.
  - done is high in the cycle after edge N+11.
- Back-pressure: while out_ready=0, the block stalls indefinitely with no change to any output.
- start while in SEND or FIN is ignored. No new snapshot is taken and no clear_req is issued.
- start held high across FIN is accepted in the following IDLE cycle.
- Reset mid-stream aborts immediately: no done and no further clear_req. After release the block is in IDLE with zeroed outputs.
- Changes on bins_flat after the snapshot have no effect on the streamed data.

Decomposition:
- Package hist_pkg holds:
  - the NUM_BINS, CNT_W, IDX_W, FIRST_VAL and BIN_SPAN constants;
  - the state encoding (IDLE=0, SEND=1, FIN=2);
  - a bin-lower-value function mapping idx to FIRST_VAL+idx*BIN_SPAN.
- One sub-module, hist_stats_acc. It holds the total and mode registers and takes clear, accept, idx and count as inputs. It can be reused by future histogram variants.

Test Plan:
- Bins all 0, out_ready=1, start pulse:
  - clear_req high for one cycle;
  - 11 beats with idx 0..10, out_lo 17,19,...,37, counts 0;
  - out_last only on idx 10;
  - done in the cycle after the 11th beat;
  - total=0, mode_idx=0, mode_count=0.
- Bin i = i+1 (1..11): total=66, mode_idx=10, mode_count=11; beat idx 4 shows out_lo=25, out_count=5.
- Tie case, bins 3 and 7 = 31 and all others = 5: total=107, mode_idx=3, mode_count=31.
- out_ready toggles 1,0,0,1,... with random stalls, and bins_flat changed after start:
  - beats carry the original snapshot and are held stable during stalls;
  - exactly 11 accepted beats; done is a single pulse.
- start pulsed during SEND at beat 3: no second clear_req, the stream is unaffected, and exactly one done.
- rst_n asserted low after beat 5, then a new start with bins all 2:
  - at reset: outputs 0, no done;
  - on the new stream: total=22, mode_idx=0, mode_count=2.
